// File: rtl/tx_fs4_upconverter_if.sv
// Sample and control bundle between the transmit baseband chain and the fs/4 upconverter.
// The master side drives baseband samples and control; the slave side returns the mixed stream.
interface tx_fs4_upconverter_if #(
    parameter int WIDTH = 18
);
    logic                    sam_clk_ena;
    logic signed [WIDTH-1:0] i_in;
    logic signed [WIDTH-1:0] q_in;
    logic        [1:0]       mode;
    logic        [1:0]       phase_offset;
    logic                    phase_sync;
    logic                    sat_clear;

    logic signed [WIDTH-1:0] tx_out;
    logic                    tx_valid;
    logic        [1:0]       nco_phase;
    logic        [1:0]       mode_active;
    logic        [15:0]      sat_count;

    modport master (
        output sam_clk_ena, i_in, q_in, mode, phase_offset, phase_sync, sat_clear,
        input  tx_out, tx_valid, nco_phase, mode_active, sat_count
    );

    modport slave (
        input  sam_clk_ena, i_in, q_in, mode, phase_offset, phase_sync, sat_clear,
        output tx_out, tx_valid, nco_phase, mode_active, sat_count
    );
endinterface

// File: rtl/tx_fs4_upconverter.sv
// Quarter-rate I/Q mixer producing the real transmit stream: two-stage pipeline,
// mode changes only at carrier phase 0, saturating negation with an event counter.
module tx_fs4_upconverter #(
    parameter int WIDTH        = 18,
    parameter bit PHASE_ON_ENA = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    tx_fs4_upconverter_if.slave bus
);

    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic        [15:0]      SAT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_PASS = 2'd2,
        MODE_MUTE = 2'd3
    } mode_e;

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("tx_fs4_upconverter: WIDTH must be within 4..32");
    end

    // The only out-of-range negation is the most negative code; clamp it to full scale.
    function automatic logic signed [WIDTH-1:0] sat_negate(input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] r;
        if (x == MIN_VAL) begin
            r = MAX_VAL;
        end else begin
            r = -x;
        end
        return r;
    endfunction

    function automatic logic negate_overflows(input logic signed [WIDTH-1:0] x);
        return (x == MIN_VAL);
    endfunction

    logic                    adv_s;
    logic        [1:0]       cur_s;
    logic                    mode_load_s;
    mode_e                   cap_mode_s;
    logic        [1:0]       eff_s;

    logic        [1:0]       phase_cnt_r;
    mode_e                   mode_active_r;

    logic                    s1_adv_r;
    logic signed [WIDTH-1:0] s1_i_r;
    logic signed [WIDTH-1:0] s1_q_r;
    logic        [1:0]       s1_eff_r;
    mode_e                   s1_mode_r;

    logic signed [WIDTH-1:0] neg_i_s;
    logic signed [WIDTH-1:0] neg_q_s;
    logic signed [WIDTH-1:0] sel_s;
    logic                    sat_s;
    logic                    sat_pulse_s;

    logic signed [WIDTH-1:0] tx_out_r;
    logic                    tx_valid_r;
    logic        [1:0]       nco_phase_r;
    logic        [15:0]      sat_count_r;

    // Decode of advance, selected phase, mode load and effective phase for this cycle
    always_comb begin
        adv_s = PHASE_ON_ENA ? bus.sam_clk_ena : 1'b1;
        if (bus.phase_sync) begin
            cur_s = 2'd0;
        end else begin
            cur_s = phase_cnt_r;
        end
        mode_load_s = adv_s & (cur_s == 2'd0);
        if (mode_load_s) begin
            cap_mode_s = mode_e'(bus.mode);
        end else begin
            cap_mode_s = mode_active_r;
        end
        eff_s = cur_s + bus.phase_offset;
    end

    // Carrier phase counter: advances on adv, resyncs to zero on phase_sync
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt_r <= 2'd0;
        end else if (adv_s) begin
            phase_cnt_r <= cur_s + 2'd1;
        end else if (bus.phase_sync) begin
            phase_cnt_r <= 2'd0;
        end else begin
            phase_cnt_r <= phase_cnt_r;
        end
    end

    // Active mode only switches at carrier phase 0 so a cycle is never split across modes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_active_r <= MODE_MUTE;
        end else if (mode_load_s) begin
            mode_active_r <= mode_e'(bus.mode);
        end else begin
            mode_active_r <= mode_active_r;
        end
    end

    // Stage 1: capture baseband pair with its phase and the mode it must be mixed with
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_adv_r  <= 1'b0;
            s1_i_r    <= {WIDTH{1'b0}};
            s1_q_r    <= {WIDTH{1'b0}};
            s1_eff_r  <= 2'd0;
            s1_mode_r <= MODE_MUTE;
        end else begin
            s1_adv_r <= adv_s;
            if (adv_s) begin
                s1_i_r    <= bus.i_in;
                s1_q_r    <= bus.q_in;
                s1_eff_r  <= eff_s;
                s1_mode_r <= cap_mode_s;
            end else begin
                s1_i_r    <= s1_i_r;
                s1_q_r    <= s1_q_r;
                s1_eff_r  <= s1_eff_r;
                s1_mode_r <= s1_mode_r;
            end
        end
    end

    // Output selection: a quarter-rate carrier is just a rotation through Q, I, -Q, -I
    always_comb begin
        neg_i_s = sat_negate(s1_i_r);
        neg_q_s = sat_negate(s1_q_r);
        sel_s   = {WIDTH{1'b0}};
        sat_s   = 1'b0;
        case (s1_mode_r)
            MODE_UP: begin
                case (s1_eff_r)
                    2'd0:    sel_s = s1_q_r;
                    2'd1:    sel_s = s1_i_r;
                    2'd2:    begin sel_s = neg_q_s; sat_s = negate_overflows(s1_q_r); end
                    2'd3:    begin sel_s = neg_i_s; sat_s = negate_overflows(s1_i_r); end
                    default: sel_s = {WIDTH{1'b0}};
                endcase
            end
            MODE_DOWN: begin
                case (s1_eff_r)
                    2'd0:    sel_s = s1_q_r;
                    2'd1:    begin sel_s = neg_i_s; sat_s = negate_overflows(s1_i_r); end
                    2'd2:    begin sel_s = neg_q_s; sat_s = negate_overflows(s1_q_r); end
                    2'd3:    sel_s = s1_i_r;
                    default: sel_s = {WIDTH{1'b0}};
                endcase
            end
            MODE_PASS: sel_s = s1_i_r;
            MODE_MUTE: sel_s = {WIDTH{1'b0}};
            default:   sel_s = {WIDTH{1'b0}};
        endcase
    end

    assign sat_pulse_s = s1_adv_r & sat_s;

    // Stage 2: registered transmit sample, its phase and the one-cycle valid strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_out_r    <= {WIDTH{1'b0}};
            tx_valid_r  <= 1'b0;
            nco_phase_r <= 2'd0;
        end else begin
            tx_valid_r <= s1_adv_r;
            if (s1_adv_r) begin
                tx_out_r    <= sel_s;
                nco_phase_r <= s1_eff_r;
            end else begin
                tx_out_r    <= tx_out_r;
                nco_phase_r <= nco_phase_r;
            end
        end
    end

    // Saturation event counter; clear has priority over a coincident event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count_r <= 16'd0;
        end else if (bus.sat_clear) begin
            sat_count_r <= 16'd0;
        end else if (sat_pulse_s && (sat_count_r != SAT_MAX)) begin
            sat_count_r <= sat_count_r + 16'd1;
        end else begin
            sat_count_r <= sat_count_r;
        end
    end

    assign bus.tx_out      = tx_out_r;
    assign bus.tx_valid    = tx_valid_r;
    assign bus.nco_phase   = nco_phase_r;
    assign bus.mode_active = mode_active_r;
    assign bus.sat_count   = sat_count_r;

endmodule

// File: tb/tb_tx_fs4_upconverter.sv
// Bench for tx_fs4_upconverter: one free-running and one enable-gated instance share
// the same stimulus and are compared every cycle against a carrier-arithmetic model.
module tb_tx_fs4_upconverter;

    localparam int     W    = 18;
    localparam longint MAXV = 131071;
    localparam longint MINV = -131072;

    typedef struct {
        longint val;
        int     eff;
        bit     sat;
        int     due;
    } rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic                ena    = 1'b1;
    logic signed [W-1:0] i_v    = 18'sd100;
    logic signed [W-1:0] q_v    = -18'sd50;
    logic        [1:0]   mode_v = 2'd0;
    logic        [1:0]   off_v  = 2'd0;
    logic                sync_v = 1'b0;
    logic                clr_v  = 1'b0;

    int total = 0;
    int bad   = 0;

    // model state, index 0 = free-running instance, 1 = enable-gated instance
    int     edge_n = 0;
    int     m_ph    [2] = '{0, 0};
    int     m_mode  [2] = '{3, 3};
    longint m_tx    [2] = '{0, 0};
    int     m_eff   [2] = '{0, 0};
    bit     m_valid [2] = '{1'b0, 1'b0};
    int     m_sat   [2] = '{0, 0};
    rec_t   mq      [2][$];

    tx_fs4_upconverter_if #(.WIDTH(W)) bus_a ();
    tx_fs4_upconverter_if #(.WIDTH(W)) bus_b ();

    assign bus_a.sam_clk_ena  = ena;
    assign bus_a.i_in         = i_v;
    assign bus_a.q_in         = q_v;
    assign bus_a.mode         = mode_v;
    assign bus_a.phase_offset = off_v;
    assign bus_a.phase_sync   = sync_v;
    assign bus_a.sat_clear    = clr_v;
    assign bus_b.sam_clk_ena  = ena;
    assign bus_b.i_in         = i_v;
    assign bus_b.q_in         = q_v;
    assign bus_b.mode         = mode_v;
    assign bus_b.phase_offset = off_v;
    assign bus_b.phase_sync   = sync_v;
    assign bus_b.sat_clear    = clr_v;

    tx_fs4_upconverter #(.WIDTH(W), .PHASE_ON_ENA(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    tx_fs4_upconverter #(.WIDTH(W), .PHASE_ON_ENA(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // transmitted value = I*sin + Q*cos of the quarter-rate carrier, clamped to WIDTH
    function automatic longint carrier(input int md, input int eff, input longint iv,
                                       input longint qv, output bit sat);
        longint c, s, v;
        c = (eff == 0) ? 1 : ((eff == 2) ? -1 : 0);
        s = (eff == 1) ? 1 : ((eff == 3) ? -1 : 0);
        case (md)
            0:       v = iv * s + qv * c;
            1:       v = -iv * s + qv * c;
            2:       v = iv;
            default: v = 0;
        endcase
        sat = 1'b0;
        if (v > MAXV) begin
            v = MAXV; sat = 1'b1;
        end else if (v < MINV) begin
            v = MINV; sat = 1'b1;
        end
        return v;
    endfunction

    task automatic model_step(input int k);
        rec_t r;
        bit   adv;
        bit   inc;
        int   cur;
        m_valid[k] = 1'b0;
        inc        = 1'b0;
        while (mq[k].size() > 0 && mq[k][0].due <= edge_n) begin
            r          = mq[k].pop_front();
            m_tx[k]    = r.val;
            m_eff[k]   = r.eff;
            m_valid[k] = 1'b1;
            inc        = r.sat;
        end
        if (clr_v) m_sat[k] = 0;
        else if (inc && m_sat[k] < 65535) m_sat[k] = m_sat[k] + 1;
        adv = (k == 0) ? 1'b1 : ena;
        cur = sync_v ? 0 : m_ph[k];
        if (adv) begin
            if (cur == 0) m_mode[k] = int'(mode_v);
            r.eff = (cur + int'(off_v)) % 4;
            r.val = carrier(m_mode[k], r.eff, i_v, q_v, r.sat);
            r.due = edge_n + 1;
            mq[k].push_back(r);
            m_ph[k] = (cur + 1) % 4;
        end else if (sync_v) begin
            m_ph[k] = 0;
        end
    endtask

    // model update
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            edge_n = 0;
            for (int k = 0; k < 2; k++) begin
                m_ph[k] = 0; m_mode[k] = 3; m_tx[k] = 0; m_eff[k] = 0;
                m_valid[k] = 1'b0; m_sat[k] = 0; mq[k].delete();
            end
        end else begin
            edge_n++;
            model_step(0);
            model_step(1);
        end
    end

    // every-cycle comparison of both instances against the model
    initial forever begin
        @(negedge clk);
        check("a.tx_out",      bus_a.tx_out,      m_tx[0]);
        check("a.tx_valid",    bus_a.tx_valid,    m_valid[0]);
        check("a.nco_phase",   bus_a.nco_phase,   m_eff[0]);
        check("a.mode_active", bus_a.mode_active, m_mode[0]);
        check("a.sat_count",   bus_a.sat_count,   m_sat[0]);
        check("b.tx_out",      bus_b.tx_out,      m_tx[1]);
        check("b.tx_valid",    bus_b.tx_valid,    m_valid[1]);
        check("b.nco_phase",   bus_b.nco_phase,   m_eff[1]);
        check("b.mode_active", bus_b.mode_active, m_mode[1]);
        check("b.sat_count",   bus_b.sat_count,   m_sat[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph(input string nm, input int ph);
        int n = 0;
        while (m_ph[0] != ph && n < 16) begin
            tick();
            n++;
        end
        check({nm, ".reach_phase"}, m_ph[0], ph);
    endtask

    task automatic expect_cycle(input string nm, input longint e0, input longint e1,
                                input longint e2, input longint e3);
        int n = 0;
        while (bus_a.nco_phase != 2'd0 && n < 16) begin
            tick();
            n++;
        end
        check({nm, ".sync"}, bus_a.nco_phase, 0);
        check({nm, ".eff0"}, bus_a.tx_out, e0); tick();
        check({nm, ".eff1"}, bus_a.tx_out, e1); tick();
        check({nm, ".eff2"}, bus_a.tx_out, e2); tick();
        check({nm, ".eff3"}, bus_a.tx_out, e3);
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.tx_out", bus_a.tx_out, 0);
        check("rst.tx_valid", bus_a.tx_valid, 0);
        check("rst.nco_phase", bus_a.nco_phase, 0);
        check("rst.mode_active", bus_a.mode_active, 3);
        check("rst.sat_count", bus_a.sat_count, 0);
        reset = 1'b0;

        // mode 0 from the first advance: -50, 100, 50, -100
        tick();
        check("first.mode_active", bus_a.mode_active, 0);
        check("first.tx_valid", bus_a.tx_valid, 0);
        tick();
        check("m0.s0", bus_a.tx_out, -50);
        check("m0.valid", bus_a.tx_valid, 1);
        check("m0.b.s0", bus_b.tx_out, -50);
        tick(); check("m0.s1", bus_a.tx_out, 100);
        tick(); check("m0.s2", bus_a.tx_out, 50);
        tick(); check("m0.s3", bus_a.tx_out, -100);

        // inverted spectrum, then a phase offset
        mode_v = 2'd1;
        repeat (8) tick();
        expect_cycle("m1", -50, -100, 50, 100);
        off_v = 2'd1;
        repeat (6) tick();
        expect_cycle("m1off", -50, -100, 50, 100);

        // gated advance with an I ramp in passthrough
        mode_v = 2'd2;
        for (int r = 0; r < 12; r++) begin
            ena = 1'b1; i_v = r[W-1:0];
            tick();
            ena = 1'b0;
            tick();
            check("ramp.valid_hi", bus_b.tx_valid, 1);
            if (r >= 4) check("ramp.value", bus_b.tx_out, r);
            tick();
            check("ramp.valid_lo", bus_b.tx_valid, 0);
            tick();
        end
        check("ramp.last", bus_b.tx_out, 11);
        check("ramp.mode", bus_b.mode_active, 2);

        // mode 0 -> 3 requested at phase 2
        ena = 1'b1; i_v = 18'sd100; q_v = -18'sd50; off_v = 2'd0; mode_v = 2'd0;
        repeat (8) tick();
        wait_ph("mute", 2);
        mode_v = 2'd3;
        tick(); check("mute.hold1", bus_a.mode_active, 0);
        tick(); check("mute.s2", bus_a.tx_out, 50);
        check("mute.hold2", bus_a.mode_active, 0);
        tick(); check("mute.s3", bus_a.tx_out, -100);
        check("mute.switch", bus_a.mode_active, 3);
        tick(); check("mute.zero", bus_a.tx_out, 0);

        // saturating negation of the most negative Q
        q_v = {1'b1, 17'd0}; mode_v = 2'd0;
        repeat (8) tick();
        n = 0;
        while (bus_a.nco_phase != 2'd2 && n < 16) begin tick(); n++; end
        check("sat.sync", bus_a.nco_phase, 2);
        check("sat.value", bus_a.tx_out, 131071);
        force dut_a.sat_count_r = 16'hFFFF;
        m_sat[0] = 65535;
        tick();
        release dut_a.sat_count_r;
        repeat (8) tick();
        check("sat.hold", bus_a.sat_count, 65535);
        n = 0;
        while (!(mq[0].size() > 0 && mq[0][0].sat) && n < 16) begin tick(); n++; end
        check("clr.reach", (mq[0].size() > 0) ? int'(mq[0][0].sat) : 0, 1);
        clr_v = 1'b1;
        tick();
        clr_v = 1'b0;
        check("clr.wins", bus_a.sat_count, 0);
        repeat (8) tick();
        check("sat.two", bus_a.sat_count, 2);

        // phase resync at phase 2
        wait_ph("sync", 2);
        sync_v = 1'b1;
        tick();
        sync_v = 1'b0;
        tick();
        check("sync.q", bus_a.tx_out, -131072);
        check("sync.eff", bus_a.nco_phase, 0);
        tick();
        check("sync.i", bus_a.tx_out, 100);
        ena = 1'b0; tick();
        sync_v = 1'b1; tick();
        sync_v = 1'b0; tick();
        ena = 1'b1;
        repeat (6) tick();

        // asynchronous reset mid-stream
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst.tx_out", bus_a.tx_out, 0);
        check("arst.tx_valid", bus_a.tx_valid, 0);
        check("arst.mode_active", bus_a.mode_active, 3);
        check("arst.sat_count", bus_a.sat_count, 0);
        check("arst.b.mode_active", bus_b.mode_active, 3);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
